// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and ALU-side signals for the two-port ALU arbiter.
// slave = arbiter side, master = clients plus the ALU.
interface alu_arbiter_if;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [15:0] req_a_i;
  logic [15:0] req_b_i;
  logic [5:0]  req_inst_i;
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready_i;
  logic [15:0] rsp_data_o;
  logic [1:0]  rsp_ovf_o;
  logic [7:0]  alu_a_o;
  logic [7:0]  alu_b_o;
  logic [2:0]  alu_inst_o;
  logic [7:0]  alu_data_i;
  logic        alu_ovf_i;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_inst_i, rsp_ready_i, alu_data_i, alu_ovf_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_ovf_o, alu_a_o, alu_b_o, alu_inst_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_inst_i, rsp_ready_i, alu_data_i, alu_ovf_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_ovf_o, alu_a_o, alu_b_o, alu_inst_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin, credit-gated sharing of one pipelined 8-bit ALU between two requesters.
// Results are steered back through a tag pipeline into per-requester response FIFOs.
module alu_arbiter #(
  parameter int RSP_DEPTH = 4,
  parameter int ALU_LAT   = 2
) (
  input logic          clk_p_i,
  input logic          reset_p_i,
  alu_arbiter_if.slave bus
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam int TL = ALU_LAT + 1;

  logic [CW-1:0] r_count    [2];
  logic [CW-1:0] r_inflight [2];
  logic [PW-1:0] r_wr_ptr   [2];
  logic [PW-1:0] r_rd_ptr   [2];
  logic [8:0]    r_mem      [2][RSP_DEPTH];
  logic [TL-1:0] r_tag_v;
  logic [TL-1:0] r_tag_id;
  logic          r_rr;
  logic [7:0]    r_alu_a;
  logic [7:0]    r_alu_b;
  logic [2:0]    r_alu_inst;

  logic [1:0]    w_elig;
  logic          w_gnt;
  logic          w_gnt_id;
  logic [1:0]    w_issue;
  logic [1:0]    w_pop;
  logic [1:0]    w_push;
  logic [7:0]    w_a;
  logic [7:0]    w_b;
  logic [2:0]    w_inst;
  logic [1:0]    w_rsp_valid;
  logic [15:0]   w_rsp_data;
  logic [1:0]    w_rsp_ovf;

  // Credit is what remains after stored and in-flight results, both registered.
  always_comb begin
    w_elig      = '0;
    w_pop       = '0;
    w_rsp_valid = '0;
    w_rsp_data  = '0;
    w_rsp_ovf   = '0;
    for (int r = 0; r < 2; r++) begin
      w_elig[r] = bus.req_valid_i[r] && !reset_p_i &&
                  (({1'b0, r_count[r]} + {1'b0, r_inflight[r]}) < (CW+1)'(RSP_DEPTH));
      w_rsp_valid[r] = (r_count[r] != '0) && !reset_p_i;
      w_pop[r]       = bus.rsp_ready_i[r] && w_rsp_valid[r];
      if (w_rsp_valid[r]) begin
        w_rsp_data[8*r +: 8] = r_mem[r][r_rd_ptr[r]][7:0];
        w_rsp_ovf[r]         = r_mem[r][r_rd_ptr[r]][8];
      end
    end
  end

  assign w_gnt    = |w_elig;
  assign w_gnt_id = (&w_elig) ? r_rr : w_elig[1];
  assign w_issue  = w_gnt ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign w_a      = w_gnt_id ? bus.req_a_i[15:8]   : bus.req_a_i[7:0];
  assign w_b      = w_gnt_id ? bus.req_b_i[15:8]   : bus.req_b_i[7:0];
  assign w_inst   = w_gnt_id ? bus.req_inst_i[5:3] : bus.req_inst_i[2:0];

  // The tail tag lines up with the cycle in which the ALU presents that op's result.
  assign w_push[0] = r_tag_v[TL-1] && !r_tag_id[TL-1];
  assign w_push[1] = r_tag_v[TL-1] &&  r_tag_id[TL-1];

  assign bus.req_ready_o = w_issue;
  assign bus.rsp_valid_o = w_rsp_valid;
  assign bus.rsp_data_o  = w_rsp_data;
  assign bus.rsp_ovf_o   = w_rsp_ovf;
  assign bus.alu_a_o     = r_alu_a;
  assign bus.alu_b_o     = r_alu_b;
  assign bus.alu_inst_o  = r_alu_inst;

  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      r_rr       <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_inst <= '0;
      r_tag_v    <= '0;
      r_tag_id   <= '0;
      for (int r = 0; r < 2; r++) begin
        r_count[r]    <= '0;
        r_inflight[r] <= '0;
        r_wr_ptr[r]   <= '0;
        r_rd_ptr[r]   <= '0;
      end
    end else begin
      if (w_gnt) begin
        r_alu_a    <= w_a;
        r_alu_b    <= w_b;
        r_alu_inst <= w_inst;
        r_rr       <= ~w_gnt_id;
      end
      r_tag_v  <= {r_tag_v[TL-2:0], w_gnt};
      r_tag_id <= {r_tag_id[TL-2:0], w_gnt_id};
      for (int r = 0; r < 2; r++) begin
        r_inflight[r] <= r_inflight[r] + CW'(w_issue[r]) - CW'(w_push[r]);
        r_count[r]    <= r_count[r] + CW'(w_push[r]) - CW'(w_pop[r]);
        if (w_push[r]) r_wr_ptr[r] <= r_wr_ptr[r] + PW'(1);
        if (w_pop[r])  r_rd_ptr[r] <= r_rd_ptr[r] + PW'(1);
      end
    end
  end

  // Storage needs no reset: the counts alone decide what is visible.
  always_ff @(posedge clk_p_i) begin
    for (int r = 0; r < 2; r++) begin
      if (w_push[r]) r_mem[r][r_wr_ptr[r]] <= {bus.alu_ovf_i, bus.alu_data_i};
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter with a 2-stage ALU model and a
// scoreboard of expected responses per requester.
module tb_alu_arbiter;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter #(.RSP_DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
    .clk_p_i  (clk),
    .reset_p_i(rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference ALU: {overflow, result}; overflow is signed for ADD/SUB.
  function automatic logic [8:0] alu_ref(input logic [2:0] inst, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic       o;
    o = 1'b0;
    case (inst)
      3'd0: begin r = a + b; o = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin r = a - b; o = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[2:0];
      3'd6: r = a >> b[2:0];
      default: r = ~a;
    endcase
    return {o, r};
  endfunction

  // External ALU: LAT register stages after the arbiter's input registers.
  logic [8:0] alu_s [LAT];
  initial for (int i = 0; i < LAT; i++) alu_s[i] = '0;
  always @(posedge clk) begin
    alu_s[0] <= alu_ref(bus.alu_inst_o, bus.alu_a_o, bus.alu_b_o);
    for (int i = 1; i < LAT; i++) alu_s[i] <= alu_s[i-1];
  end
  assign bus.alu_data_i = alu_s[LAT-1][7:0];
  assign bus.alu_ovf_i  = alu_s[LAT-1][8];

  // Scoreboard: accepted-but-not-popped ops per requester, with the cycle each becomes visible.
  typedef struct {
    logic [8:0] v;
    int         rc;
  } ent_t;
  ent_t sbq [2][$];
  int   mcyc = 0;
  logic mrr = 1'b0;
  int   rsp_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    logic [1:0] elig;
    logic [1:0] exp_rdy;
    logic       exp_v;
    int         g;
    ent_t       e;
    if (rst) begin
      chk("reset_req_ready", bus.req_ready_o, 0);
      chk("reset_rsp_valid", bus.rsp_valid_o, 0);
      chk("reset_rsp_data", {bus.rsp_ovf_o, bus.rsp_data_o}, 0);
      sbq[0].delete();
      sbq[1].delete();
      mrr = 1'b0;
    end else begin
      for (int r = 0; r < 2; r++)
        elig[r] = bus.req_valid_i[r] && (sbq[r].size() < DEPTH);
      g = -1;
      if (elig == 2'b11)  g = int'(mrr);
      else if (elig[0])   g = 0;
      else if (elig[1])   g = 1;
      exp_rdy = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
      chk("req_ready", bus.req_ready_o, exp_rdy);
      for (int r = 0; r < 2; r++) begin
        exp_v = (sbq[r].size() > 0) && (sbq[r][0].rc <= mcyc);
        chk($sformatf("rsp_valid%0d", r), bus.rsp_valid_o[r], exp_v);
        if (exp_v) begin
          chk($sformatf("rsp_data%0d", r), {bus.rsp_ovf_o[r], bus.rsp_data_o[8*r +: 8]}, sbq[r][0].v);
          if (bus.rsp_ready_i[r]) begin
            void'(sbq[r].pop_front());
            rsp_cnt[r]++;
          end
        end
      end
      if (g >= 0) begin
        e.v  = alu_ref(bus.req_inst_i[3*g +: 3], bus.req_a_i[8*g +: 8], bus.req_b_i[8*g +: 8]);
        e.rc = mcyc + LAT + 2;
        sbq[g].push_back(e);
        mrr = (g == 0);
      end
    end
    mcyc++;
  end

  // ---------------- driver ----------------
  logic [1:0] acc;

  task automatic cyc_end();
    @(negedge clk);
    acc = bus.req_valid_i & bus.req_ready_o;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] inst);
    bus.req_a_i[8*r +: 8]    = a;
    bus.req_b_i[8*r +: 8]    = b;
    bus.req_inst_i[3*r +: 3] = inst;
  endtask

  task automatic new_op(input int r);
    set_op(r, 8'($urandom), 8'($urandom), 3'($urandom));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.req_valid_i = 2'b00;
    repeat (n) cyc_end();
    rst = 1'b0;
  endtask

  // Ends on a negedge; lat = -1 if no response within the budget.
  task automatic wait_rsp(input int r, output int lat);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      if (bus.rsp_valid_o[r]) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int n;
    int c0;
    int c1;
    bus.req_valid_i = 2'b00;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.req_inst_i  = '0;
    bus.rsp_ready_i = 2'b11;

    do_reset(2);
    chk("post_reset_alu_a", bus.alu_a_o, 0);
    chk("post_reset_alu_b", bus.alu_b_o, 0);
    chk("post_reset_alu_inst", bus.alu_inst_o, 0);
    chk("post_reset_rsp_valid", bus.rsp_valid_o, 0);

    // single op
    set_op(0, 8'd20, 8'd30, 3'd0);
    bus.req_valid_i = 2'b01;
    cyc_end();
    chk("single_ready", acc, 2'b01);
    bus.req_valid_i = 2'b00;
    wait_rsp(0, lat);
    chk("single_latency", lat, 4);
    chk("single_data", bus.rsp_data_o[7:0], 8'd50);
    chk("single_ovf", bus.rsp_ovf_o[0], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_one_cycle", bus.rsp_valid_o[0], 1'b0);
    @(posedge clk); #1;

    // fairness
    do_reset(2);
    c0 = rsp_cnt[0];
    c1 = rsp_cnt[1];
    new_op(0);
    new_op(1);
    bus.req_valid_i = 2'b11;
    for (int k = 0; k < 10; k++) begin
      cyc_end();
      chk("fair_grant", acc, (k % 2 == 0) ? 2'b01 : 2'b10);
      for (int r = 0; r < 2; r++) if (acc[r]) new_op(r);
    end
    bus.req_valid_i = 2'b00;
    repeat (8) cyc_end();
    chk("fair_rsp0", rsp_cnt[0] - c0, 5);
    chk("fair_rsp1", rsp_cnt[1] - c1, 5);

    // backpressure on requester 1
    do_reset(2);
    bus.rsp_ready_i = 2'b01;
    new_op(1);
    bus.req_valid_i = 2'b10;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc_end();
      if (acc[1]) begin
        n++;
        new_op(1);
      end
    end
    chk("bp_accepts", n, 4);
    bus.rsp_ready_i = 2'b11;
    cyc_end();
    chk("bp_no_same_cycle_credit", acc[1], 1'b0);
    bus.rsp_ready_i = 2'b01;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      cyc_end();
      if (acc[1]) begin
        n++;
        new_op(1);
      end
    end
    chk("bp_one_more", n, 1);
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b11;
    repeat (10) cyc_end();

    // overflow passthrough
    set_op(1, 8'd100, 8'd100, 3'd0);
    bus.req_valid_i = 2'b10;
    cyc_end();
    chk("ovf_accept", acc, 2'b10);
    bus.req_valid_i = 2'b00;
    wait_rsp(1, lat);
    chk("ovf_latency", lat, 4);
    chk("ovf_flag", bus.rsp_ovf_o[1], 1'b1);
    chk("ovf_data", bus.rsp_data_o[15:8], 8'd200);
    @(posedge clk); #1;

    // reset mid-flight
    new_op(0);
    bus.req_valid_i = 2'b01;
    cyc_end();
    new_op(0);
    cyc_end();
    bus.req_valid_i = 2'b00;
    cyc_end();
    rst = 1'b1;
    cyc_end();
    rst = 1'b0;
    repeat (6) cyc_end();
    bus.rsp_ready_i = 2'b00;
    new_op(0);
    bus.req_valid_i = 2'b01;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      cyc_end();
      if (acc[0]) begin
        n++;
        new_op(0);
      end
    end
    chk("rst_refill", n, 4);
    bus.req_valid_i = 2'b00;

    // simultaneous push/pop on FIFO0 holding 3 entries
    do_reset(2);
    bus.rsp_ready_i = 2'b00;
    new_op(0);
    bus.req_valid_i = 2'b01;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      cyc_end();
      if (acc[0]) begin
        n++;
        new_op(0);
      end
    end
    chk("pp_fill", n, 4);
    bus.req_valid_i = 2'b00;
    cyc_end();
    cyc_end();
    bus.rsp_ready_i = 2'b01;
    cyc_end();
    bus.rsp_ready_i = 2'b00;
    bus.req_valid_i = 2'b01;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      cyc_end();
      if (acc[0]) begin
        n++;
        new_op(0);
      end
    end
    chk("pp_credit", n, 1);
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b11;
    repeat (10) cyc_end();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc_end();
      for (int r = 0; r < 2; r++) begin
        if (acc[r]) begin
          if ($urandom_range(0, 1) == 1) new_op(r);
          else bus.req_valid_i[r] = 1'b0;
        end else if (!bus.req_valid_i[r] && $urandom_range(0, 2) == 0) begin
          new_op(r);
          bus.req_valid_i[r] = 1'b1;
        end
      end
      bus.rsp_ready_i = 2'($urandom);
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b11;
    repeat (12) cyc_end();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
